// File: rtl/core_bus_arbiter_pkg.sv
// Shared definitions for the core bus arbiter: FSM states, grant encodings and
// the round-robin grant selection.
package core_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   // On a tie the port that did not win last time is granted
   function automatic grant_t pick_grant(input logic i_pend, input logic d_pend, input grant_t last);
      grant_t g;
      if (i_pend && d_pend) begin
         g = (last == GRANT_I) ? GRANT_D : GRANT_I;
      end else if (d_pend) begin
         g = GRANT_D;
      end else begin
         g = GRANT_I;
      end
      return g;
   endfunction

endpackage

// File: rtl/core_bus_arbiter_timeout.sv
// Watchdog counter for an outstanding bus transaction. expired is high during
// the TIMEOUT_CYCLES-th consecutive enabled cycle; tied low when disabled.
module bus_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_disabled
         logic unused_inputs_s;
         assign unused_inputs_s = &{1'b0, clk, reset, clear, enable};
         assign expired = 1'b0;
      end else begin : g_enabled
         localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [CW-1:0] COUNT_MAX  = CW'(TIMEOUT_CYCLES);
         localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);
         localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

         logic [CW-1:0] count_r;

         // Count enabled cycles, saturating rather than wrapping
         always_ff @(posedge clk) begin
            if (reset || clear) begin
               count_r <= {CW{1'b0}};
            end else if (enable && (count_r != COUNT_MAX)) begin
               count_r <= count_r + COUNT_ONE;
            end else begin
               count_r <= count_r;
            end
         end

         assign expired = enable && (count_r == COUNT_LAST);
      end
   endgenerate

endmodule

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter joining the core's instruction and data ports onto the
// Controller's single memory port, with a watchdog for unacknowledged requests.
module core_bus_arbiter
   import core_bus_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_WIDTH-1:0] ERROR_DATA = 32'hDEADBEEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [DATA_WIDTH-1:0] i_read_data,
   output logic                  i_response,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [DATA_WIDTH-1:0] d_write_data,
   output logic [DATA_WIDTH-1:0] d_read_data,
   output logic                  d_response,
   output logic                  m_read,
   output logic                  m_write,
   output logic [ADDR_WIDTH-1:0] m_address,
   output logic [DATA_WIDTH-1:0] m_write_data,
   input  logic [DATA_WIDTH-1:0] m_read_data,
   input  logic                  m_response,
   output logic                  bus_error
);

   arb_state_t state_r, state_nxt_s;
   grant_t last_grant_r, last_grant_nxt_s, grant_s;

   logic                  m_read_r, m_read_nxt_s;
   logic                  m_write_r, m_write_nxt_s;
   logic [ADDR_WIDTH-1:0] m_address_r, m_address_nxt_s;
   logic [DATA_WIDTH-1:0] m_write_data_r, m_write_data_nxt_s;
   logic                  i_response_r, i_response_nxt_s;
   logic                  d_response_r, d_response_nxt_s;
   logic [DATA_WIDTH-1:0] i_read_data_r, i_read_data_nxt_s;
   logic [DATA_WIDTH-1:0] d_read_data_r, d_read_data_nxt_s;
   logic                  bus_error_r, bus_error_nxt_s;
   logic                  i_pend_s, d_pend_s, expired_s;

   assign i_pend_s = i_read;
   assign d_pend_s = d_read | d_write;

   bus_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_r != BUSY),
      .enable (state_r == BUSY),
      .expired(expired_s)
   );

   // Next-state and next-output decode; responses default low with zero data
   always_comb begin
      state_nxt_s        = state_r;
      last_grant_nxt_s   = last_grant_r;
      grant_s            = GRANT_I;
      m_read_nxt_s       = m_read_r;
      m_write_nxt_s      = m_write_r;
      m_address_nxt_s    = m_address_r;
      m_write_data_nxt_s = m_write_data_r;
      i_response_nxt_s   = 1'b0;
      d_response_nxt_s   = 1'b0;
      i_read_data_nxt_s  = {DATA_WIDTH{1'b0}};
      d_read_data_nxt_s  = {DATA_WIDTH{1'b0}};
      bus_error_nxt_s    = bus_error_r;
      case (state_r)
         IDLE: begin
            if (i_pend_s || d_pend_s) begin
               grant_s          = pick_grant(i_pend_s, d_pend_s, last_grant_r);
               last_grant_nxt_s = grant_s;
               state_nxt_s      = BUSY;
               if (grant_s == GRANT_I) begin
                  m_read_nxt_s       = 1'b1;
                  m_write_nxt_s      = 1'b0;
                  m_address_nxt_s    = i_address;
                  m_write_data_nxt_s = {DATA_WIDTH{1'b0}};
               end else begin
                  // A read/write collision on the data port becomes a write
                  m_read_nxt_s       = d_read & ~d_write;
                  m_write_nxt_s      = d_write;
                  m_address_nxt_s    = d_address;
                  m_write_data_nxt_s = d_write_data;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUSY: begin
            if (m_response || expired_s) begin
               m_read_nxt_s  = 1'b0;
               m_write_nxt_s = 1'b0;
               state_nxt_s   = RESP;
               if (!m_response) begin
                  bus_error_nxt_s = 1'b1;
               end else begin
                  bus_error_nxt_s = bus_error_r;
               end
               if (last_grant_r == GRANT_I) begin
                  i_response_nxt_s  = 1'b1;
                  i_read_data_nxt_s = m_response ? m_read_data : ERROR_DATA;
               end else begin
                  d_response_nxt_s  = 1'b1;
                  d_read_data_nxt_s = m_response ? m_read_data : ERROR_DATA;
               end
            end else begin
               state_nxt_s = BUSY;
            end
         end
         RESP: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= IDLE;
         last_grant_r   <= GRANT_D;
         m_read_r       <= 1'b0;
         m_write_r      <= 1'b0;
         m_address_r    <= {ADDR_WIDTH{1'b0}};
         m_write_data_r <= {DATA_WIDTH{1'b0}};
         i_response_r   <= 1'b0;
         d_response_r   <= 1'b0;
         i_read_data_r  <= {DATA_WIDTH{1'b0}};
         d_read_data_r  <= {DATA_WIDTH{1'b0}};
         bus_error_r    <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         last_grant_r   <= last_grant_nxt_s;
         m_read_r       <= m_read_nxt_s;
         m_write_r      <= m_write_nxt_s;
         m_address_r    <= m_address_nxt_s;
         m_write_data_r <= m_write_data_nxt_s;
         i_response_r   <= i_response_nxt_s;
         d_response_r   <= d_response_nxt_s;
         i_read_data_r  <= i_read_data_nxt_s;
         d_read_data_r  <= d_read_data_nxt_s;
         bus_error_r    <= bus_error_nxt_s;
      end
   end

   assign m_read       = m_read_r;
   assign m_write      = m_write_r;
   assign m_address    = m_address_r;
   assign m_write_data = m_write_data_r;
   assign i_response   = i_response_r;
   assign d_response   = d_response_r;
   assign i_read_data  = i_read_data_r;
   assign d_read_data  = d_read_data_r;
   assign bus_error    = bus_error_r;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed and randomized transaction-level checks of core_bus_arbiter against
// a port/round-robin/timeout reference model (TIMEOUT_CYCLES = 8).
module tb_core_bus_arbiter;
   localparam int T = 8;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_read, d_read, d_write, m_response;
   logic [31:0] i_address, d_address, d_write_data, m_read_data;
   logic [31:0] i_read_data, d_read_data, m_address, m_write_data;
   logic        i_response, d_response, m_read, m_write, bus_error;

   int total = 0;
   int bad = 0;
   bit model_last;   // last granted port: 0 = instruction, 1 = data
   bit exp_err;

   always #5 clk = ~clk;

   core_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T), .ERROR_DATA(ERR)) dut (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_address(i_address), .i_read_data(i_read_data), .i_response(i_response),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_write_data(d_write_data),
      .d_read_data(d_read_data), .d_response(d_response),
      .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_write_data(m_write_data),
      .m_read_data(m_read_data), .m_response(m_response), .bus_error(bus_error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".m_read"}, 64'(m_read), 64'd0);
      chk({tag, ".m_write"}, 64'(m_write), 64'd0);
      chk({tag, ".i_resp"}, 64'(i_response), 64'd0);
      chk({tag, ".d_resp"}, 64'(d_response), 64'd0);
      chk({tag, ".i_data"}, 64'(i_read_data), 64'd0);
      chk({tag, ".d_data"}, 64'(d_read_data), 64'd0);
   endtask

   task automatic drop_requests();
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
   endtask

   task automatic reset_dut(input string tag);
      reset = 1'b1; drop_requests(); m_response = 1'b0;
      step();
      chk_quiet(tag);
      chk({tag, ".addr"}, 64'(m_address), 64'd0);
      chk({tag, ".wdata"}, 64'(m_write_data), 64'd0);
      chk({tag, ".bus_error"}, 64'(bus_error), 64'd0);
      reset = 1'b0;
      model_last = 1'b1;
      exp_err = 1'b0;
   endtask

   // One transaction; entered and left at a negedge with the DUT idle.
   // ack_delay >= T means the Controller never answers.
   task automatic txn(input string tag, input bit ir, input bit dr, input bit dw,
                      input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                      input int ack_delay, input logic [31:0] rdata, input bit hold);
      bit exp_d, to, exp_rd, exp_wr;
      logic [31:0] exp_addr, exp_resp;
      int ncyc;
      i_read = ir; d_read = dr; d_write = dw;
      i_address = ia; d_address = da; d_write_data = wd;
      if (ir && (dr || dw)) exp_d = !model_last;
      else exp_d = !ir;
      model_last = exp_d;
      exp_wr   = exp_d && dw;
      exp_rd   = exp_d ? (dr && !dw) : 1'b1;
      exp_addr = exp_d ? da : ia;
      to       = (ack_delay >= T);
      exp_resp = to ? ERR : rdata;
      ncyc     = to ? T : ack_delay + 1;
      step();
      for (int c = 0; c < ncyc; c++) begin
         chk({tag, ".m_read"}, 64'(m_read), 64'(exp_rd));
         chk({tag, ".m_write"}, 64'(m_write), 64'(exp_wr));
         chk({tag, ".m_addr"}, 64'(m_address), 64'(exp_addr));
         if (exp_wr) chk({tag, ".m_wdata"}, 64'(m_write_data), 64'(wd));
         chk({tag, ".busy_resp"}, 64'({i_response, d_response}), 64'd0);
         if (!to && c == ack_delay) begin
            m_response = 1'b1; m_read_data = rdata;
         end else begin
            m_response = 1'b0; m_read_data = $urandom;
         end
         // inputs changing while busy must not matter
         if (!hold) begin
            i_address = $urandom; d_address = $urandom; d_write_data = $urandom;
         end
         step();
      end
      m_response = 1'b0;
      if (to) exp_err = 1'b1;
      chk({tag, ".resp_m_req"}, 64'({m_read, m_write}), 64'd0);
      chk({tag, ".i_resp"}, 64'(i_response), 64'(!exp_d));
      chk({tag, ".d_resp"}, 64'(d_response), 64'(exp_d));
      chk({tag, ".i_data"}, 64'(i_read_data), exp_d ? 64'd0 : 64'(exp_resp));
      chk({tag, ".d_data"}, 64'(d_read_data), exp_d ? 64'(exp_resp) : 64'd0);
      chk({tag, ".bus_error"}, 64'(bus_error), 64'(exp_err));
      if (!hold) drop_requests();
      step();
      chk_quiet({tag, ".after"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      bit ir, dr, dw;
      reset = 1'b1; drop_requests(); m_response = 1'b0; m_read_data = 32'h0;
      i_address = 32'h0; d_address = 32'h0; d_write_data = 32'h0;
      @(negedge clk);
      reset_dut("reset");

      txn("fetch", 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 0, 32'h00000013, 1'b0);

      reset_dut("reset2");
      for (int k = 0; k < 4; k++)
         txn($sformatf("alt%0d", k), 1'b1, 1'b0, 1'b1, 32'h0, 32'h2000, 32'hCAFEF00D,
             k, 32'h1111_0000 + 32'(k), k != 3);

      txn("collision", 1'b0, 1'b1, 1'b1, 32'h0, 32'h3000, 32'h12345678, 2, 32'h5A5A5A5A, 1'b0);
      txn("slow", 1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h0, 5, 32'hA5A5_0001, 1'b0);
      txn("timeout", 1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, 20, 32'h0, 1'b0);

      // late acknowledge with nothing outstanding
      m_response = 1'b1; m_read_data = 32'h77777777;
      for (int k = 0; k < 2; k++) begin
         step();
         chk_quiet("stray");
         chk("stray.bus_error", 64'(bus_error), 64'd1);
      end
      m_response = 1'b0;
      step();

      for (int k = 0; k < 24; k++) begin
         ir = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
         if (!ir && !dr && !dw) ir = 1'b1;
         txn($sformatf("rand%0d", k), ir, dr, dw, $urandom, $urandom, $urandom,
             $urandom_range(0, 10), $urandom, 1'($urandom));
      end
      drop_requests();
      step();

      // reset in the middle of a transaction
      d_read = 1'b1; d_address = 32'h80;
      step();
      chk("midrst.m_read", 64'(m_read), 64'd1);
      reset = 1'b1; drop_requests(); m_response = 1'b0;
      step();
      chk_quiet("midrst");
      chk("midrst.bus_error", 64'(bus_error), 64'd0);
      reset = 1'b0;
      model_last = 1'b1; exp_err = 1'b0;
      step();
      chk_quiet("midrst.idle");
      txn("postrst", 1'b1, 1'b1, 1'b0, 32'h500, 32'h600, 32'h0, 1, 32'hBEEF0001, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Two-port to one-port memory bus arbiter between a Harvard-style core (instruction port plus data port) and the Controller's single core memory port.
- Serialises requests with round-robin priority and forwards one transaction at a time.
- Returns responses to the originating port.
- A watchdog completes any transaction the Controller never acknowledges, so a hung bus cannot stall the core forever.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- TIMEOUT_CYCLES, 1024, maximum cycles a master transaction may stay outstanding; 0 disables the watchdog.
- ERROR_DATA, 32'hDEADBEEF, read data returned on timeout.

Ports:
- clk  in  1  system clock; the single clock of the block.
- reset  in  1  synchronous, active-high reset.
- i_read  in  1  instruction fetch request, level, held until i_response.
- i_address  in  ADDR_WIDTH  fetch address.
- i_read_data  out  DATA_WIDTH  fetch data, valid while i_response=1.
- i_response  out  1  one-cycle completion pulse, instruction port.
- d_read  in  1  data read request, level.
- d_write  in  1  data write request, level.
- d_address  in  ADDR_WIDTH  data address.
- d_write_data  in  DATA_WIDTH  store data.
- d_read_data  out  DATA_WIDTH  load data, valid while d_response=1.
- d_response  out  1  one-cycle completion pulse, data port.
- m_read  out  1  read request to Controller (core_read_memory).
- m_write  out  1  write request to Controller (core_write_memory).
- m_address  out  ADDR_WIDTH  address to Controller.
- m_write_data  out  DATA_WIDTH  write data to Controller.
- m_read_data  in  DATA_WIDTH  read data from Controller.
- m_response  in  1  completion from Controller.
- bus_error  out  1  sticky flag, set on any timeout.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0.
  - State goes to IDLE, timeout counter clears.
  - last_grant=DATA, so the instruction port wins the first tie.
  - Reset asserted mid-transaction drops the transaction; no response pulse is produced.
- States:
  - IDLE:
    - Samples requests.
    - Only i_read pending -> grant I.
    - Only d_read/d_write pending -> grant D.
    - Both pending -> grant the port not equal to last_grant.
    - On grant: register m_* from the granted port, update last_grant, go to BUSY.
    - No request -> stay in IDLE.
  - BUSY:
    - m_* outputs are registered and held constant.
    - Counter increments each cycle.
    - m_response=1 -> capture m_read_data, clear m_read/m_write, go to RESP.
    - Counter reaches TIMEOUT_CYCLES with no m_response (and TIMEOUT_CYCLES≠0) -> capture ERROR_DATA, set bus_error, clear m_read/m_write, go to RESP.
    - If m_response and timeout coincide, m_response wins.
  - RESP:
    - Pulse i_response or d_response for exactly one cycle, with the captured data on the matching *_read_data.
    - Go to IDLE.
    - *_read_data returns to 0 when the response is low.
- Data port collisions: d_read and d_write both high -> write only (m_write=1, m_read=0).
- Instruction port is read-only; m_write is never driven from it.
- Write transactions return the captured m_read_data on d_read_data; the core ignores it.
- m_response outside BUSY (e.g. a late ack after a timeout) is ignored.
- Requesters must deassert their request by the edge following their response pulse. A request still high in IDLE starts a new transaction.
- Requester inputs are sampled only in IDLE. Changes during BUSY/RESP do not affect the outstanding transaction.
- Latency:
  - Request visible at cycle 0 -> m_* asserted at cycle 1.
  - m_response at cycle k -> port response at k+1.
  - Minimum round trip is 2 cycles; minimum issue spacing is 3 cycles.
- bus_error clears only on reset.
- Width rule: the counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates, never wraps.

Decomposition:
- Shared defs include:
  - State encodings: IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - Grant encodings: GRANT_I=1'b0, GRANT_D=1'b1.
- One sub-module, bus_timeout_counter:
  - Inputs: clk, reset, clear, enable.
  - Output: expired.
  - Parameterised by TIMEOUT_CYCLES.
  - expired is constant 0 when TIMEOUT_CYCLES=0.

Test Plan:
- Single fetch, ack on first cycle: i_read, i_address=0x100; m_response with m_read_data=0x00000013 on the first cycle m_read is high -> m_read high at cycle 1, i_response with i_read_data=0x00000013 at cycle 2, d_response never asserted.
- Simultaneous requests after reset: i_read at 0x0 and d_write at 0x2000 with data 0xCAFEF00D -> instruction granted first, then m_write=1, m_address=0x2000, m_write_data=0xCAFEF00D; with both held continuously, grants alternate I,D,I,D over 4 transactions.
- Collision on data port: d_read=d_write=1 -> m_write=1, m_read=0.
- Slow Controller: m_response delayed 5 cycles -> m_* stable for all 5 cycles, d_response exactly one cycle wide at ack+1.
- Timeout with TIMEOUT_CYCLES=8 and no ack: d_read at 0x40 -> m_read drops after 8 BUSY cycles, d_response with d_read_data=0xDEADBEEF, bus_error=1; a later stray m_response is ignored; bus_error stays 1 until reset.
- Mid-transaction reset: reset asserted during BUSY -> next cycle all outputs 0, no response pulse; a subsequent simultaneous request grants the instruction port.
